game_state_sequencer: RTL and testbench

Frame-rate controller that owns the top-level game mode and the shared frame timebase. It drives gameState and FrameCount into the start-screen overlay mux, sprite and scroll engines. It sequences Start -> Play <-> Pause -> GameOver -> Start from player buttons and gameplay events. It also tracks lives, issues respawn pulses, and publishes the blink phase used by the "press start" overlay.

---
 rtl/game_pkg.sv | 14 +
 rtl/btn_rise_detect.sv | 20 ++
 rtl/game_state_sequencer.sv | 127 ++++++++++++
 tb/tb_game_state_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-mode enum and frame timebase constants.
// Imported by the sequencer, overlay mux and sprite engine.
package game_pkg;

  typedef enum logic [1:0] {
    START    = 2'b00,
    PLAY     = 2'b01,
    PAUSE    = 2'b10,
    GAMEOVER = 2'b11
  } gamestate_t;

  localparam logic [5:0] FRAME_WRAP = 6'd63;

endpackage

// File: rtl/btn_rise_detect.sv
// Rising-edge detector for a synchronized button level.
// Ports: clk, rst (sync, active-high), i_level in, o_rise out.
module btn_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_rise
);

  logic r_q;

  // History follows the input even during reset, so a button held
  // through reset is not seen as a fresh press afterwards.
  always_ff @(posedge clk) begin
    r_q <= i_level;
  end

  assign o_rise = i_level & ~r_q & ~rst;

endmodule

// File: rtl/game_state_sequencer.sv
// Top-level game mode FSM, lives/respawn, GameOver timer, frame timebase.
// Ports: frame_Clk, Reset, buttons/events in; gameState, FrameCount,
// blink_on, lives, respawn, freeze out (all registered).
module game_state_sequencer
  import game_pkg::*;
#(
  parameter logic [1:0] LIVES_INIT      = 2'd3,
  parameter logic [7:0] GAMEOVER_FRAMES = 8'd180
) (
  input  logic       frame_Clk,
  input  logic       Reset,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       player_dead,
  input  logic       level_clear,
  output logic [1:0] gameState,
  output logic [5:0] FrameCount,
  output logic       blink_on,
  output logic [1:0] lives,
  output logic       respawn,
  output logic       freeze
);

  gamestate_t r_state;
  gamestate_t w_state;
  logic [1:0] r_lives;
  logic [1:0] w_lives;
  logic [7:0] r_go_cnt;
  logic [7:0] w_go_cnt;
  logic       r_respawn;
  logic       w_respawn;
  logic       r_freeze;
  logic [5:0] r_frame;
  logic       r_blink;
  logic       w_start_rise;
  logic       w_pause_rise;

  btn_rise_detect u_start_rise (
    .clk    (frame_Clk),
    .rst    (Reset),
    .i_level(start_btn),
    .o_rise (w_start_rise)
  );

  btn_rise_detect u_pause_rise (
    .clk    (frame_Clk),
    .rst    (Reset),
    .i_level(pause_btn),
    .o_rise (w_pause_rise)
  );

  always_comb begin
    w_state   = r_state;
    w_lives   = r_lives;
    w_go_cnt  = r_go_cnt;
    w_respawn = 1'b0;
    unique case (r_state)
      START: begin
        if (w_start_rise) begin
          w_state   = PLAY;
          w_lives   = LIVES_INIT;
          w_respawn = 1'b1;
        end
      end
      PLAY: begin
        // Death outranks level end, which outranks pause.
        if (player_dead) begin
          if (r_lives <= 2'd1) begin
            w_state  = GAMEOVER;
            w_lives  = 2'd0;
            w_go_cnt = 8'd0;
          end else begin
            w_lives   = r_lives - 2'd1;
            w_respawn = 1'b1;
          end
        end else if (level_clear) begin
          w_state = START;
        end else if (w_pause_rise) begin
          w_state = PAUSE;
        end
      end
      PAUSE: begin
        if (w_pause_rise | w_start_rise) begin
          w_state = PLAY;
        end
      end
      GAMEOVER: begin
        if (r_go_cnt == GAMEOVER_FRAMES - 8'd1) begin
          w_state  = START;
          w_go_cnt = 8'd0;
        end else begin
          w_go_cnt = r_go_cnt + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      r_state   <= START;
      r_lives   <= 2'd0;
      r_go_cnt  <= 8'd0;
      r_respawn <= 1'b0;
      r_freeze  <= 1'b0;
      r_frame   <= 6'd0;
      r_blink   <= 1'b1;
    end else begin
      r_state   <= w_state;
      r_lives   <= w_lives;
      r_go_cnt  <= w_go_cnt;
      r_respawn <= w_respawn;
      r_freeze  <= (w_state == PAUSE) || (w_state == GAMEOVER);
      r_frame   <= r_frame + 6'd1;
      if (r_frame == FRAME_WRAP) begin
        r_blink <= ~r_blink;
      end
    end
  end

  assign gameState  = r_state;
  assign FrameCount = r_frame;
  assign blink_on   = r_blink;
  assign lives      = r_lives;
  assign respawn    = r_respawn;
  assign freeze     = r_freeze;

endmodule

// File: tb/tb_game_state_sequencer.sv
// Directed + random bench for game_state_sequencer against a
// frame-level reference model of the game rules.
module tb_game_state_sequencer;

  localparam int LIVES = 3;
  localparam int GOF   = 180;

  logic       frame_Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       start_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic       player_dead = 1'b0;
  logic       level_clear = 1'b0;
  logic [1:0] gameState;
  logic [5:0] FrameCount;
  logic       blink_on;
  logic [1:0] lives;
  logic       respawn;
  logic       freeze;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: mode 0 start, 1 play, 2 pause, 3 over
  int m_mode = 0;
  int m_lives = 0;
  int m_resp = 0;
  int m_n = 0;
  int m_go_entry = 0;
  bit m_sq = 0;
  bit m_pq = 0;

  game_state_sequencer dut (
    .frame_Clk  (frame_Clk),
    .Reset      (Reset),
    .start_btn  (start_btn),
    .pause_btn  (pause_btn),
    .player_dead(player_dead),
    .level_clear(level_clear),
    .gameState  (gameState),
    .FrameCount (FrameCount),
    .blink_on   (blink_on),
    .lives      (lives),
    .respawn    (respawn),
    .freeze     (freeze)
  );

  always #5 frame_Clk = ~frame_Clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit sr, pr;
    sr = start_btn && !m_sq;
    pr = pause_btn && !m_pq;
    m_sq = start_btn;
    m_pq = pause_btn;
    if (Reset) begin
      m_mode = 0; m_lives = 0; m_resp = 0; m_n = 0;
      return;
    end
    m_n++;
    m_resp = 0;
    case (m_mode)
      0: if (sr) begin
        m_mode = 1; m_lives = LIVES; m_resp = 1;
      end
      1: if (player_dead) begin
        if (m_lives == 1) begin
          m_mode = 3; m_lives = 0; m_go_entry = m_n;
        end else begin
          m_lives--; m_resp = 1;
        end
      end else if (level_clear) m_mode = 0;
      else if (pr) m_mode = 2;
      2: if (pr || sr) m_mode = 1;
      default: if (m_n - m_go_entry == GOF) m_mode = 0;
    endcase
  endtask

  task automatic frame(input bit r, s, p, d, l);
    Reset = r; start_btn = s; pause_btn = p;
    player_dead = d; level_clear = l;
    @(posedge frame_Clk);
    model_step();
    #1;
    chk("gameState", 8'(gameState), 8'(m_mode));
    chk("FrameCount", 8'(FrameCount), 8'(m_n % 64));
    chk("blink_on", 8'(blink_on), 8'(((m_n / 64) % 2) == 0));
    chk("lives", 8'(lives), 8'(m_lives));
    chk("respawn", 8'(respawn), 8'(m_resp));
    chk("freeze", 8'(freeze), 8'(m_mode >= 2));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) frame(0, 0, 0, 0, 0);
  endtask

  initial begin
    // 1: reset then idle through two FrameCount wraps
    frame(1, 0, 0, 0, 0);
    frame(1, 0, 0, 0, 0);
    idle(130);
    chk("idle_state", 8'(gameState), 8'd0);
    // 2: start held 10 frames -> one transition
    for (int i = 0; i < 10; i++) frame(0, 1, 0, 0, 0);
    chk("held_start_play", 8'(gameState), 8'd1);
    chk("held_start_lives", 8'(lives), 8'd3);
    idle(3);
    // 3: three deaths 5 frames apart, then GameOver timeout
    for (int k = 0; k < 3; k++) begin
      frame(0, 0, 0, 1, 0);
      idle(4);
    end
    chk("over_state", 8'(gameState), 8'd3);
    idle(GOF - 6);
    chk("over_hold", 8'(gameState), 8'd3);
    idle(3);
    chk("over_done", 8'(gameState), 8'd0);
    // 4: pause, death ignored while paused, resume
    frame(0, 1, 0, 0, 0);
    idle(2);
    frame(0, 0, 1, 0, 0);
    chk("paused", 8'(gameState), 8'd2);
    idle(2);
    frame(0, 0, 0, 1, 0);
    frame(0, 0, 0, 0, 1);
    idle(2);
    frame(0, 0, 1, 0, 0);
    chk("resumed", 8'(gameState), 8'd1);
    chk("resumed_lives", 8'(lives), 8'd3);
    idle(2);
    // 5: death + pause same frame with lives 2
    frame(0, 0, 0, 1, 0);
    idle(2);
    frame(0, 0, 1, 1, 0);
    chk("dp_state", 8'(gameState), 8'd1);
    chk("dp_lives", 8'(lives), 8'd1);
    idle(2);
    // 6: reset during GameOver, start held across reset release
    frame(0, 0, 0, 1, 0);
    idle(100);
    frame(1, 1, 0, 0, 0);
    frame(1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) frame(0, 1, 0, 0, 0);
    chk("held_reset_start", 8'(gameState), 8'd0);
    idle(2);
    frame(0, 1, 0, 0, 0);
    chk("repress_play", 8'(gameState), 8'd1);
    idle(2);
    // random play
    for (int i = 0; i < 2000; i++) begin
      frame(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 9) < 2),
            ($urandom_range(0, 9) < 2),
            ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 79) == 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
